// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and parity helper for the UART receiver
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY    = 3'd3,
`endif
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } uart_rx_state_t;

    localparam int UART_SYNC_STAGES = 2;

    // Expected parity bit for a character, zero-extended to 8 bits by the caller.
    function automatic logic uart_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - show-ahead FIFO with push/pop, full/empty and fill count
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wr_en, rd_en;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign rd_en    = pop & ~empty;
    // A pop frees the slot in the same cycle, so a push into a full FIFO still lands.
    assign wr_en    = push & (~full | rd_en);
    assign pop_data = mem_q[rptr_q];
    assign count    = count_q;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_en) begin
            mem_d[wptr_q] = push_data;
            wptr_d        = wptr_q + AW'(1);
        end
        if (rd_en) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_flow.sv
// rtl/uart_rx_flow.sv - UART receiver with FIFO and RTS flow control; UART_RX_PARITY_EN adds parity
module uart_rx_flow
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 5,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int RTS_HI     = 12,
    parameter int RTS_LO     = 4
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            UARTn_RXD,
    output logic                            UARTn_RTS,
    output logic [DATA_BITS-1:0]            rx_data,
    output logic                            rx_valid,
    input  logic                            rx_ready,
    output logic                            frame_err,
    output logic                            overrun,
    input  logic                            overrun_clr,
`ifdef UART_RX_PARITY_EN
    output logic                            parity_err,
`endif
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);
    localparam int TW = $clog2(CLK_DIV + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [UART_SYNC_STAGES-1:0] sync_q, sync_d;
    logic                        rxd_prev_q, rxd_prev_d;
    uart_rx_state_t              state_q, state_d;
    logic [TW-1:0]               timer_q, timer_d;
    logic [3:0]                  bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]        shift_q, shift_d;
    logic                        stop_bad_q, stop_bad_d;
    logic                        frame_err_q, frame_err_d;
    logic                        overrun_q, overrun_d;
    logic                        rts_q, rts_d;
    logic                        rxd_s, tick, final_stop, stop_fail, push, pop, fifo_full, fifo_empty;
`ifdef UART_RX_PARITY_EN
    logic                        parity_bad_q, parity_bad_d;
    logic                        parity_err_q, parity_err_d;
    logic                        par_mismatch;
    logic [7:0]                  par_in;
`endif

    assign rxd_s      = sync_q[UART_SYNC_STAGES-1];
    assign sync_d     = {sync_q[UART_SYNC_STAGES-2:0], UARTn_RXD};
    assign rxd_prev_d = rxd_s;
    assign tick       = (timer_q == TW'(1));
    assign final_stop = (state_q == ST_STOP) && tick && (bit_cnt_q == 4'(STOP_BITS - 1));
    assign stop_fail  = stop_bad_q | ~rxd_s;
    assign pop        = rx_valid & rx_ready;

`ifdef UART_RX_PARITY_EN
    always_comb begin
        par_in                 = '0;
        par_in[DATA_BITS-1:0]  = shift_q;
        par_mismatch           = rxd_s ^ uart_parity(par_in, PARITY_ODD);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q       <= '1;
            rxd_prev_q   <= 1'b1;
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            stop_bad_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            rts_q        <= 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q       <= sync_d;
            rxd_prev_q   <= rxd_prev_d;
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            stop_bad_q   <= stop_bad_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            rts_q        <= rts_d;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= parity_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        stop_bad_d = stop_bad_q;
`ifdef UART_RX_PARITY_EN
        parity_bad_d = parity_bad_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rxd_prev_q && !rxd_s) begin
                    state_d = ST_START;
                    timer_d = TW'(CLK_DIV / 2);
                end
            end
            ST_START: begin
                if (tick) begin
                    // A start bit that is high again at mid-bit was only a glitch.
                    state_d   = rxd_s ? ST_IDLE : ST_DATA;
                    timer_d   = TW'(CLK_DIV);
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                    timer_d = TW'(CLK_DIV);
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        bit_cnt_d  = '0;
                        stop_bad_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                        state_d    = ST_PARITY;
`else
                        state_d    = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    parity_bad_d = par_mismatch;
                    timer_d      = TW'(CLK_DIV);
                    state_d      = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    timer_d    = TW'(CLK_DIV);
                    stop_bad_d = stop_fail;
                    if (final_stop) begin
                        bit_cnt_d = '0;
                        state_d   = stop_fail ? ST_WAIT_IDLE : ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (rxd_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
`ifdef UART_RX_PARITY_EN
        push         = final_stop & ~stop_fail & ~parity_bad_q;
        parity_err_d = (state_q == ST_PARITY) & tick & par_mismatch;
`else
        push         = final_stop & ~stop_fail;
`endif
        frame_err_d  = final_stop & stop_fail;
        // Setting wins over a simultaneous clear so no overrun is ever lost.
        if (push && fifo_full && !pop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
        if (fifo_count >= CW'(RTS_HI)) begin
            rts_d = 1'b1;
        end else if (fifo_count <= CW'(RTS_LO)) begin
            rts_d = 1'b0;
        end else begin
            rts_d = rts_q;
        end
    end

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shift_q),
        .pop       (pop),
        .pop_data  (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rx_valid  = ~fifo_empty;
    assign UARTn_RTS = rts_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_flow.sv
// tb/tb_uart_rx_flow.sv - scoreboard bench for uart_rx_flow
module tb_uart_rx_flow;
    localparam int CLK_DIV = 5;
    localparam int DEPTH   = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic       overrun_clr = 1'b0;
    logic       rts, rx_valid, frame_err, overrun;
    logic [7:0] rx_data;
    logic [4:0] fifo_count;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    int         pe_cnt = 0;
`endif

    int         errors = 0;
    int         checks = 0;
    int         fe_cnt = 0;
    logic [7:0] exp_q[$];

    always #3 clk = ~clk;

    uart_rx_flow dut (
        .clk         (clk),
        .rst         (rst),
        .UARTn_RXD   (rxd),
        .UARTn_RTS   (rts),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
`ifdef UART_RX_PARITY_EN
        .parity_err  (parity_err),
`endif
        .fifo_count  (fifo_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) fe_cnt++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) pe_cnt++;
`endif
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) check_eq("pop_unexpected", exp_q.size(), 1);
                else check_eq("rx_data", {24'b0, rx_data}, {24'b0, exp_q.pop_front()});
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        cycles(CLK_DIV);
    endtask

    task automatic send_char(input logic [7:0] d, input logic par, input logic stop);
        logic good;
        good = stop;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
        good = good && (par == ^d);
`else
        good = good && (par == par);
`endif
        drive_bit(stop);
        if (good && exp_q.size() < DEPTH) exp_q.push_back(d);
        drive_bit(1'b1);
        drive_bit(1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        rx_ready = 1'b1;
        while (rx_valid && n < 40) begin
            cycles(1);
            n++;
        end
        rx_ready = 1'b0;
        cycles(2);
        check_eq("drain_count", fifo_count, 0);
        check_eq("drain_sb", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        cycles(3);
        check_eq("rst_rts", rts, 1);
        check_eq("rst_valid", rx_valid, 0);
        check_eq("rst_count", fifo_count, 0);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_overrun", overrun, 0);
        rst = 1'b0;
        cycles(1);
        check_eq("rts_after_reset", rts, 0);
        cycles(4);

        // single character, show-ahead head and pop
        send_char(8'hA5, ^8'hA5, 1'b1);
        check_eq("a5_valid", rx_valid, 1);
        check_eq("a5_head", rx_data, 8'hA5);
        check_eq("a5_count", fifo_count, 1);
        rx_ready = 1'b1;
        cycles(1);
        rx_ready = 1'b0;
        check_eq("a5_popped_valid", rx_valid, 0);
        check_eq("a5_popped_count", fifo_count, 0);

        // two-cycle low glitch on idle line
        rxd = 1'b0;
        cycles(2);
        rxd = 1'b1;
        cycles(20);
        check_eq("glitch_count", fifo_count, 0);
        check_eq("glitch_frame_err", fe_cnt, 0);

        // bad stop bit, then a clean character
        send_char(8'h55, ^8'h55, 1'b0);
        cycles(3);
        check_eq("ferr_pulses", fe_cnt, 1);
        check_eq("ferr_count", fifo_count, 0);
        send_char(8'h3C, ^8'h3C, 1'b1);
        check_eq("3c_count", fifo_count, 1);
        check_eq("3c_head", rx_data, 8'h3C);
        drain();

        // RTS hysteresis
        for (int i = 0; i < 12; i++) begin
            d = 8'(i * 17 + 3);
            send_char(d, ^d, 1'b1);
            if (i == 10) check_eq("rts_at_11", rts, 0);
        end
        cycles(3);
        check_eq("rts_count_12", fifo_count, exp_q.size());
        check_eq("rts_at_12", rts, 1);
        rx_ready = 1'b1;
        cycles(7);
        rx_ready = 1'b0;
        cycles(2);
        check_eq("rts_count_5", fifo_count, 5);
        check_eq("rts_hold_5", rts, 1);
        rx_ready = 1'b1;
        cycles(1);
        rx_ready = 1'b0;
        cycles(2);
        check_eq("rts_count_4", fifo_count, 4);
        check_eq("rts_at_4", rts, 0);
        drain();

        // overrun with 17 characters into depth 16
        for (int i = 0; i < 17; i++) begin
            d = 8'(i * 29 + 7);
            send_char(d, ^d, 1'b1);
            if (i == 15) check_eq("ovr_before", overrun, 0);
        end
        check_eq("ovr_set", overrun, 1);
        check_eq("ovr_count", fifo_count, 16);
        check_eq("ovr_head", rx_data, 8'h07);
        check_eq("ovr_rts", rts, 1);
        overrun_clr = 1'b1;
        cycles(1);
        overrun_clr = 1'b0;
        check_eq("ovr_cleared", overrun, 0);
        drain();
        check_eq("final_frame_err", fe_cnt, 1);

`ifdef UART_RX_PARITY_EN
        send_char(8'h07, 1'b0, 1'b1);
        cycles(3);
        check_eq("par_pulses", pe_cnt, 1);
        check_eq("par_count", fifo_count, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
